exe_memreq: RTL and testbench

EXE_MEMREQ -- requirements
Module: exe_memreq

---
 rtl/exe_memreq_pkg.sv | 43 ++++
 rtl/exe_st_align.sv | 44 ++++
 rtl/exe_memreq.sv | 150 +++++++++++++++
 tb/tb_exe_memreq.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_memreq_pkg.sv
// Shared encodings for the EXE-stage memory request block: access sizes,
// load/store one-hot bit positions, request FSM states and the EXE payload.
package exe_memreq_pkg;

  // id_ld_op is one-hot {b, bu, h, hu, w}
  localparam int unsigned LD_B  = 4;
  localparam int unsigned LD_BU = 3;
  localparam int unsigned LD_H  = 2;
  localparam int unsigned LD_HU = 1;
  localparam int unsigned LD_W  = 0;

  // id_st_op is one-hot {b, h, w}
  localparam int unsigned ST_B = 2;
  localparam int unsigned ST_H = 1;
  localparam int unsigned ST_W = 0;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    REQ_IDLE = 2'd0,
    REQ_PEND = 2'd1,
    REQ_DONE = 2'd2
  } req_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  ld_op;
    logic [2:0]  st_op;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] st_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        excep;
  } exe_payload_t;

  function automatic logic is_memop(input logic [4:0] ld_op, input logic [2:0] st_op);
    return (|ld_op) | (|st_op);
  endfunction

endpackage

// File: rtl/exe_st_align.sv
// Address-dependent access attributes: alignment exception, SRAM size code,
// byte-lane write strobes and lane-replicated store data.
module exe_st_align
  import exe_memreq_pkg::*;
(
  input  logic [4:0]  ld_op,
  input  logic [2:0]  st_op,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        ale,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);

  logic op_b;
  logic op_h;
  logic op_w;

  always_comb begin
    op_b = ld_op[LD_B] | ld_op[LD_BU] | st_op[ST_B];
    op_h = ld_op[LD_H] | ld_op[LD_HU] | st_op[ST_H];
    op_w = ld_op[LD_W] | st_op[ST_W];

    ale = (op_h & addr[0]) | (op_w & (addr[1:0] != 2'b00));

    if (op_b)      size = SIZE_B;
    else if (op_h) size = SIZE_H;
    else           size = SIZE_W;

    wstrb = '0;
    wdata = st_data;
    if (st_op[ST_B]) begin
      wstrb = 4'b0001 << addr[1:0];
      wdata = {4{st_data[7:0]}};
    end else if (st_op[ST_H]) begin
      wstrb = 4'b0011 << {addr[1], 1'b0};
      wdata = {2{st_data[15:0]}};
    end else if (st_op[ST_W]) begin
      wstrb = 4'b1111;
    end
  end

endmodule

// File: rtl/exe_memreq.sv
// EXE pipeline stage issuing data-SRAM requests: holds the instruction,
// runs the IDLE/PEND/DONE address-handshake FSM and handles flush discard.
module exe_memreq
  import exe_memreq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,

  input  logic        ID_valid,
  output logic        EXE_allowin,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_ld_op,
  input  logic [2:0]  id_st_op,
  input  logic [31:0] id_base,
  input  logic [31:0] id_offset,
  input  logic [31:0] id_st_data,
  input  logic        id_rf_we,
  input  logic [4:0]  id_rf_waddr,
  input  logic        id_excep,

  input  logic        MEM_allowin,
  input  logic        EXE_flush,
  input  logic        MEM_to_EXE_excep,

  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,

  output logic        MEM_valid,
  output logic [31:0] mem_pc,
  output logic [4:0]  mem_ld_op,
  output logic        mem_rf_we,
  output logic [4:0]  mem_rf_waddr,
  output logic [31:0] mem_addr,
  output logic        mem_data_req,
  output logic        mem_excp_ale,
  output logic        mem_discard_ok
);

  exe_payload_t pl;
  exe_payload_t id_pl;
  logic         valid;
  req_state_t   state;
  logic         flush_pend;

  logic [31:0]  addr;
  logic         memop;
  logic         ale;
  logic         req;
  logic         accept;
  logic         readygo;
  logic         kill;
  logic [1:0]   size;
  logic [3:0]   wstrb;
  logic [31:0]  wdata;

  assign addr = pl.base + pl.offset;

  exe_st_align u_align (
    .ld_op   (pl.ld_op),
    .st_op   (pl.st_op),
    .addr    (addr),
    .st_data (pl.st_data),
    .ale     (ale),
    .size    (size),
    .wstrb   (wstrb),
    .wdata   (wdata)
  );

  always_comb begin
    id_pl.pc       = id_pc;
    id_pl.ld_op    = id_ld_op;
    id_pl.st_op    = id_st_op;
    id_pl.base     = id_base;
    id_pl.offset   = id_offset;
    id_pl.st_data  = id_st_data;
    id_pl.rf_we    = id_rf_we;
    id_pl.rf_waddr = id_rf_waddr;
    id_pl.excep    = id_excep;
  end

  // A flush seen while PEND is remembered so the instruction is discarded
  // once the outstanding request is finally accepted.
  always_comb begin
    memop = is_memop(pl.ld_op, pl.st_op);
    kill  = EXE_flush | flush_pend;
    req   = 1'b0;
    if (!reset) begin
      if (state == REQ_PEND)
        req = 1'b1;
      else if (state == REQ_IDLE)
        req = valid & memop & ~ale & ~pl.excep & ~MEM_to_EXE_excep & ~EXE_flush;
    end
    accept      = req & data_sram_addr_ok;
    readygo     = ~memop | ale | pl.excep | (state == REQ_DONE) | accept;
    EXE_allowin = (~valid | (readygo & MEM_allowin)) & ~((state == REQ_PEND) & kill);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= 1'b0;
      pl         <= '0;
      state      <= REQ_IDLE;
      flush_pend <= 1'b0;
    end else if ((state == REQ_PEND) && !data_sram_addr_ok) begin
      if (EXE_flush)
        flush_pend <= 1'b1;
    end else if (kill) begin
      valid      <= 1'b0;
      state      <= REQ_IDLE;
      flush_pend <= 1'b0;
    end else if (ID_valid && EXE_allowin) begin
      valid <= 1'b1;
      pl    <= id_pl;
      state <= REQ_IDLE;
    end else if (valid && readygo && MEM_allowin) begin
      valid <= 1'b0;
      state <= REQ_IDLE;
    end else if (accept) begin
      state <= REQ_DONE;
    end else if (req) begin
      state <= REQ_PEND;
    end
  end

  always_comb begin
    data_sram_req   = req;
    data_sram_wr    = |pl.st_op;
    data_sram_size  = size;
    data_sram_wstrb = wstrb;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;

    MEM_valid      = ~reset & valid & readygo & ~kill;
    mem_data_req   = ~reset & valid & memop & ((state == REQ_DONE) | accept);
    mem_excp_ale   = ~reset & valid & ale;
    mem_discard_ok = ~reset & (state == REQ_PEND) & kill & data_sram_addr_ok;

    mem_pc       = pl.pc;
    mem_ld_op    = pl.ld_op;
    mem_rf_we    = pl.rf_we;
    mem_rf_waddr = pl.rf_waddr;
    mem_addr     = addr;
  end

endmodule

// File: tb/tb_exe_memreq.sv
// Directed bench for exe_memreq with a per-cycle behavioural scoreboard.
module tb_exe_memreq;

  localparam logic [4:0] LDB  = 5'b10000;
  localparam logic [4:0] LDBU = 5'b01000;
  localparam logic [4:0] LDH  = 5'b00100;
  localparam logic [4:0] LDW  = 5'b00001;
  localparam logic [2:0] STB  = 3'b100;
  localparam logic [2:0] STH  = 3'b010;
  localparam logic [2:0] STW  = 3'b001;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_valid, EXE_allowin;
  logic [31:0] id_pc, id_base, id_offset, id_st_data;
  logic [4:0]  id_ld_op, id_rf_waddr;
  logic [2:0]  id_st_op;
  logic        id_rf_we, id_excep;
  logic        MEM_allowin, EXE_flush, MEM_to_EXE_excep;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        MEM_valid, mem_rf_we, mem_data_req, mem_excp_ale, mem_discard_ok;
  logic [31:0] mem_pc, mem_addr;
  logic [4:0]  mem_ld_op, mem_rf_waddr;

  int n_cmp  = 0;
  int n_bad  = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  exe_memreq dut (
    .clk(clk), .reset(reset),
    .ID_valid(ID_valid), .EXE_allowin(EXE_allowin),
    .id_pc(id_pc), .id_ld_op(id_ld_op), .id_st_op(id_st_op),
    .id_base(id_base), .id_offset(id_offset), .id_st_data(id_st_data),
    .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr), .id_excep(id_excep),
    .MEM_allowin(MEM_allowin), .EXE_flush(EXE_flush), .MEM_to_EXE_excep(MEM_to_EXE_excep),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .MEM_valid(MEM_valid), .mem_pc(mem_pc), .mem_ld_op(mem_ld_op),
    .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr), .mem_addr(mem_addr),
    .mem_data_req(mem_data_req), .mem_excp_ale(mem_excp_ale),
    .mem_discard_ok(mem_discard_ok)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc, base, off, data;
    logic [4:0]  ld;
    logic [2:0]  st;
    logic        we;
    logic [4:0]  wa;
    logic        exc;
  } instr_t;

  instr_t m_ins;
  bit m_valid, m_req, m_acc, m_killed;

  function automatic int unsigned nbytes(input logic [4:0] ld, input logic [2:0] st);
    if (ld[4] | ld[3] | st[2]) return 1;
    if (ld[2] | ld[1] | st[1]) return 2;
    if (ld[0] | st[0])         return 4;
    return 0;
  endfunction

  initial begin : scoreboard
    logic [31:0] a, e_wd;
    logic [3:0]  e_strb;
    logic [1:0]  e_size;
    int unsigned n, lo, lb;
    bit memop, mis, may, e_req, hs, done, kill, e_mv, e_in, e_disc, e_dr;
    m_valid = 0; m_req = 0; m_acc = 0; m_killed = 0;
    forever begin
      @(negedge clk);
      if (!reset && data_sram_req && data_sram_addr_ok) hs_cnt++;
      if (reset) begin
        chk("rst_req", data_sram_req, 0);
        chk("rst_mem_valid", MEM_valid, 0);
        chk("rst_data_req", mem_data_req, 0);
        chk("rst_ale", mem_excp_ale, 0);
        chk("rst_discard", mem_discard_ok, 0);
        m_valid = 0; m_req = 0; m_acc = 0; m_killed = 0;
      end else begin
        a     = m_ins.base + m_ins.off;
        n     = nbytes(m_ins.ld, m_ins.st);
        memop = m_valid && (n != 0);
        mis   = 0;
        if (memop) mis = (a % n) != 0;
        may    = memop && !mis && !m_ins.exc && !MEM_to_EXE_excep && !EXE_flush && !m_acc && !m_req;
        e_req  = m_req || may;
        hs     = e_req && data_sram_addr_ok;
        done   = !memop || mis || m_ins.exc || m_acc || hs;
        kill   = EXE_flush || m_killed;
        e_mv   = m_valid && done && !kill;
        e_in   = (!m_valid || (done && MEM_allowin)) && !(m_req && kill);
        e_disc = m_req && kill && data_sram_addr_ok;
        e_dr   = memop && (m_acc || hs);

        chk("req", data_sram_req, e_req);
        chk("mem_valid", MEM_valid, e_mv);
        chk("allowin", EXE_allowin, e_in);
        chk("data_req", mem_data_req, e_dr);
        chk("ale", mem_excp_ale, m_valid && mis);
        chk("discard", mem_discard_ok, e_disc);

        if (e_req) begin
          e_size = (n == 4) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
          lo = a % 4;
          lb = lo - (lo % n);
          e_strb = '0;
          for (int unsigned i = 0; i < 4; i++) begin
            if (m_ins.st != 0 && i >= lb && i < lb + n) e_strb[i] = 1'b1;
            e_wd[8*i +: 8] = m_ins.data[8*(i % n) +: 8];
          end
          chk("sram_addr", data_sram_addr, a);
          chk("sram_wr", data_sram_wr, m_ins.st != 0);
          chk("sram_size", data_sram_size, e_size);
          chk("sram_wstrb", data_sram_wstrb, e_strb);
          if (m_ins.st != 0) chk("sram_wdata", data_sram_wdata, e_wd);
        end
        if (e_mv) begin
          chk("mem_pc", mem_pc, m_ins.pc);
          chk("mem_ld_op", mem_ld_op, m_ins.ld);
          chk("mem_rf_we", mem_rf_we, m_ins.we);
          chk("mem_rf_waddr", mem_rf_waddr, m_ins.wa);
          chk("mem_addr", mem_addr, a);
        end

        // state for the next cycle
        if (m_req && !data_sram_addr_ok) begin
          if (EXE_flush) m_killed = 1;
        end else if (kill) begin
          m_valid = 0; m_req = 0; m_acc = 0; m_killed = 0;
        end else if (ID_valid && e_in) begin
          m_valid = 1; m_req = 0; m_acc = 0; m_killed = 0;
          m_ins.pc = id_pc; m_ins.base = id_base; m_ins.off = id_offset;
          m_ins.data = id_st_data; m_ins.ld = id_ld_op; m_ins.st = id_st_op;
          m_ins.we = id_rf_we; m_ins.wa = id_rf_waddr; m_ins.exc = id_excep;
        end else if (m_valid && done && MEM_allowin) begin
          m_valid = 0; m_req = 0; m_acc = 0;
        end else if (hs) begin
          m_acc = 1; m_req = 0;
        end else if (may) begin
          m_req = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] ld, input logic [2:0] st,
                       input logic [31:0] base, off, data);
    id_pc = pc; id_ld_op = ld; id_st_op = st;
    id_base = base; id_offset = off; id_st_data = data;
    id_rf_we = (ld != 0); id_rf_waddr = pc[6:2]; id_excep = 1'b0;
  endtask

  task automatic send(input logic [31:0] pc, input logic [4:0] ld, input logic [2:0] st,
                      input logic [31:0] base, off, data);
    drive(pc, ld, st, base, off, data);
    ID_valid = 1'b1;
    #1;
    chk("allowin_at_send", EXE_allowin, 1);
    @(posedge clk);
    #1;
    ID_valid = 1'b0;
  endtask

  int hs0;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ID_valid = 1'b0; MEM_allowin = 1'b1; EXE_flush = 1'b0;
    MEM_to_EXE_excep = 1'b0; data_sram_addr_ok = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("reset_req", data_sram_req, 0);
    chk("reset_mem_valid", MEM_valid, 0);
    chk("reset_allowin", EXE_allowin, 1);
    chk("reset_mem_pc", mem_pc, 0);
    chk("reset_mem_addr", mem_addr, 0);
    step();

    // ld.w accepted in the same cycle
    send(32'h100, LDW, 0, 32'h1000, 32'h4, 0);
    #1;
    chk("ldw_req", data_sram_req, 1);
    chk("ldw_addr", data_sram_addr, 32'h1004);
    chk("ldw_size", data_sram_size, 2);
    chk("ldw_wstrb", data_sram_wstrb, 0);
    chk("ldw_data_req", mem_data_req, 1);
    chk("ldw_mem_valid", MEM_valid, 1);
    step();
    #1 chk("ldw_req_gone", data_sram_req, 0);

    // st.b at 0x2003, accepted on the fourth request cycle
    data_sram_addr_ok = 1'b0;
    send(32'h104, 0, STB, 32'h2000, 32'h3, 32'h000000AB);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) data_sram_addr_ok = 1'b1;
      #1;
      chk("stb_req", data_sram_req, 1);
      chk("stb_addr", data_sram_addr, 32'h2003);
      chk("stb_wstrb", data_sram_wstrb, 4'b1000);
      chk("stb_wdata", data_sram_wdata, 32'hABABABAB);
      chk("stb_allowin", EXE_allowin, (c == 3) ? 1 : 0);
      step();
    end
    #1 chk("stb_req_gone", data_sram_req, 0);

    // misaligned ld.h: no request, exception passed on
    send(32'h108, LDH, 0, 32'h3000, 32'h1, 0);
    #1;
    chk("ldh_req", data_sram_req, 0);
    chk("ldh_ale", mem_excp_ale, 1);
    chk("ldh_data_req", mem_data_req, 0);
    chk("ldh_mem_valid", MEM_valid, 1);
    step();
    #1 chk("ldh_gone", MEM_valid, 0);

    // st.w pending, flushed, accepted later and discarded
    data_sram_addr_ok = 1'b0;
    send(32'h10C, 0, STW, 32'h4000, 32'h8, 32'h12345678);
    #1;
    chk("stw_req", data_sram_req, 1);
    chk("stw_wstrb", data_sram_wstrb, 4'hF);
    chk("stw_wdata", data_sram_wdata, 32'h12345678);
    step();
    EXE_flush = 1'b1;
    #1;
    chk("stw_flush_req", data_sram_req, 1);
    chk("stw_flush_mv", MEM_valid, 0);
    chk("stw_flush_allowin", EXE_allowin, 0);
    step();
    EXE_flush = 1'b0;
    #1;
    chk("stw_pend_req", data_sram_req, 1);
    chk("stw_pend_mv", MEM_valid, 0);
    chk("stw_pend_allowin", EXE_allowin, 0);
    step();
    data_sram_addr_ok = 1'b1;
    #1;
    chk("stw_disc", mem_discard_ok, 1);
    chk("stw_disc_req", data_sram_req, 1);
    chk("stw_disc_mv", MEM_valid, 0);
    chk("stw_disc_allowin", EXE_allowin, 0);
    step();
    #1;
    chk("stw_after_disc", mem_discard_ok, 0);
    chk("stw_after_req", data_sram_req, 0);
    chk("stw_after_allowin", EXE_allowin, 1);

    // ld.bu accepted while MEM is stalled for three cycles
    MEM_allowin = 1'b0;
    hs0 = hs_cnt;
    send(32'h110, LDBU, 0, 32'h5000, 32'h2, 0);
    #1;
    chk("ldbu_req", data_sram_req, 1);
    chk("ldbu_size", data_sram_size, 0);
    chk("ldbu_allowin", EXE_allowin, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk("ldbu_hold_req", data_sram_req, 0);
      chk("ldbu_hold_mv", MEM_valid, 1);
      chk("ldbu_hold_data_req", mem_data_req, 1);
    end
    step();
    MEM_allowin = 1'b1;
    #1 chk("ldbu_release_allowin", EXE_allowin, 1);
    step();
    #1;
    chk("ldbu_gone", MEM_valid, 0);
    chk("ldbu_one_request", hs_cnt - hs0, 1);

    // reset while PEND
    data_sram_addr_ok = 1'b0;
    send(32'h114, 0, STH, 32'h6000, 32'h2, 32'h0000BEEF);
    #1;
    chk("sth_wstrb", data_sram_wstrb, 4'b1100);
    chk("sth_wdata", data_sram_wdata, 32'hBEEFBEEF);
    chk("sth_size", data_sram_size, 1);
    step();
    step();
    reset = 1'b1;
    #1 chk("sth_reset_req", data_sram_req, 0);
    step();
    reset = 1'b0;
    #1;
    chk("post_reset_req", data_sram_req, 0);
    chk("post_reset_mv", MEM_valid, 0);
    chk("post_reset_allowin", EXE_allowin, 1);
    data_sram_addr_ok = 1'b1;
    send(32'h118, LDW, 0, 32'h100, 32'h20, 0);
    #1 chk("post_reset_new_req", data_sram_req, 1);
    step();

    // flush in IDLE suppresses the request
    send(32'h11C, 0, STB, 32'h7000, 32'h1, 32'h55);
    EXE_flush = 1'b1;
    #1;
    chk("idle_flush_req", data_sram_req, 0);
    chk("idle_flush_mv", MEM_valid, 0);
    step();
    EXE_flush = 1'b0;
    #1 chk("idle_flush_gone", MEM_valid, 0);

    // byte load at odd address, misaligned word store, non-memory op
    send(32'h120, LDB, 0, 32'h7000, 32'h3, 0);
    #1;
    chk("ldb_odd_req", data_sram_req, 1);
    chk("ldb_odd_ale", mem_excp_ale, 0);
    step();
    send(32'h124, 0, STW, 32'h8000, 32'h2, 32'hCAFE0000);
    #1;
    chk("stw_mis_req", data_sram_req, 0);
    chk("stw_mis_ale", mem_excp_ale, 1);
    step();
    send(32'h128, 0, 0, 32'h1, 32'h1, 0);
    #1;
    chk("alu_req", data_sram_req, 0);
    chk("alu_mv", MEM_valid, 1);
    step();

    // back-to-back loads with offset wrap-around
    drive(32'h12C, LDW, 0, 32'hFFFF_FFF8, 32'h10, 0);
    ID_valid = 1'b1;
    step();
    drive(32'h130, LDH, 0, 32'h9000, 32'h6, 0);
    #1 chk("b2b_first_addr", data_sram_addr, 32'h8);
    step();
    ID_valid = 1'b0;
    #1;
    chk("b2b_second_req", data_sram_req, 1);
    chk("b2b_second_addr", data_sram_addr, 32'h9006);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
